// File: rtl/and8_operand_collector_pkg.sv
// Shared constants, state type and default padding helper for the 8-operand collector.
package and8_operand_collector_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SLOTS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // All-ones of the requested width: the identity of a bitwise AND.
  function automatic logic [63:0] pad_default(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/and8_operand_collector.sv
// Serial-to-parallel collector gathering eight operand words for the AND8 reducer.
// Define AND8_COLLECTOR_FLUSH_EN to add the flush input that pads a partial set.
module and8_operand_collector
  import and8_operand_collector_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PAD_VALUE = WIDTH'(pad_default(WIDTH))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef AND8_COLLECTOR_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] fill_cnt
);

  // Handshakes: a beat moves on a rising edge where valid && ready; in HOLD,
  // in_ready mirrors out_ready so a new word is taken only in the transfer cycle.

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] cnt_acc;
  logic [WIDTH-1:0] slot_q [NUM_SLOTS];
  logic [WIDTH-1:0] slot_d [NUM_SLOTS];
  logic             accept;
  logic             flush_req;

`ifdef AND8_COLLECTOR_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready  = (state_q == FILL) || out_ready;
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign fill_cnt  = fill_cnt_q;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    slot_d     = slot_q;
    cnt_acc    = fill_cnt_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          slot_d[fill_cnt_q[2:0]] = in_data;
          cnt_acc                 = fill_cnt_q + CNT_ONE;
        end
        fill_cnt_d = cnt_acc;
        if (cnt_acc == CNT_FULL) begin
          state_d = HOLD;
        end else if (flush_req && (fill_cnt_q != '0)) begin
          // Pad after any word stored this cycle; an empty set ignores flush.
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (CNT_W'(i) >= cnt_acc) slot_d[i] = PAD_VALUE;
          end
          fill_cnt_d = CNT_FULL;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          if (in_valid) begin
            slot_d[0]  = in_data;
            fill_cnt_d = CNT_ONE;
          end else begin
            fill_cnt_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      slot_q     <= slot_d;
    end
  end

  assign a = slot_q[0];
  assign b = slot_q[1];
  assign c = slot_q[2];
  assign d = slot_q[3];
  assign e = slot_q[4];
  assign f = slot_q[5];
  assign g = slot_q[6];
  assign h = slot_q[7];

endmodule

// File: tb/tb_and8_operand_collector.sv
// Self-checking bench for and8_operand_collector: reference model plus set scoreboard.
module tb_and8_operand_collector;

  localparam int W = 8;
  localparam logic [W-1:0] PAD = 8'hFF;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   fill_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;

  logic [8*W-1:0] exp_q[$];

  and8_operand_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef AND8_COLLECTOR_FLUSH_EN
    .flush     (flush),
`endif
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_cnt  (fill_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] mdl_slot [8];
  int           mdl_cnt;
  int           mdl_n;
  logic         mdl_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_cnt = 0;
      exp_q.delete();
    end else begin
      mdl_n   = mdl_cnt;
      mdl_acc = in_valid && ((mdl_cnt < 8) || out_ready);
      if (mdl_cnt == 8 && out_ready) mdl_n = 0;
      if (mdl_acc) begin
        mdl_slot[mdl_n] = in_data;
        mdl_n++;
      end
`ifdef AND8_COLLECTOR_FLUSH_EN
      if (flush && mdl_cnt >= 1 && mdl_cnt < 8 && mdl_n < 8) begin
        for (int i = mdl_n; i < 8; i++) mdl_slot[i] = PAD;
        mdl_n = 8;
      end
`endif
      if (mdl_n == 8 && mdl_cnt != 8)
        exp_q.push_back({mdl_slot[0], mdl_slot[1], mdl_slot[2], mdl_slot[3],
                         mdl_slot[4], mdl_slot[5], mdl_slot[6], mdl_slot[7]});
      mdl_cnt = mdl_n;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("fill_cnt", 64'(fill_cnt), 64'(mdl_cnt));
      check("out_valid", 64'(out_valid), 64'(mdl_cnt == 8));
      check("in_ready", 64'(in_ready), 64'((mdl_cnt < 8) || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_set", 64'(out_valid), 64'(0));
        end else begin
          check("set_data", {a, b, c, d, e, f, g, h}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] dat);
    bit done;
    done     = 1'b0;
    in_data  = dat;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'(done), 64'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int xfer_before;

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_fill_cnt", 64'(fill_cnt), 64'(0));
    check("reset_slots", {a, b, c, d, e, f, g, h}, 64'(0));
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // Words 1..8 with downstream ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_word(W'(i));
    in_valid = 1'b0;
    check("first_set_valid", 64'(out_valid), 64'(1));
    check("first_set_data", {a, b, c, d, e, f, g, h}, 64'h0102030405060708);
    idle(3);
    check("first_set_drained", 64'(fill_cnt), 64'(0));

    // Backpressure: hold a set of 8'hFF for 5 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(8'hFF);
    xfer_before = xfer_cnt;
    idle(5);
    check("hold_valid", 64'(out_valid), 64'(1));
    check("hold_in_ready", 64'(in_ready), 64'(0));
    check("hold_no_xfer", 64'(xfer_cnt), 64'(xfer_before));
    out_ready = 1'b1;
    idle(4);
    check("hold_one_xfer", 64'(xfer_cnt), 64'(xfer_before + 1));

    // Back-to-back stream of 16 words
    xfer_before = xfer_cnt;
    for (int i = 0; i < 16; i++) send_word(W'($urandom_range(0, 255)));
    idle(3);
    check("b2b_two_sets", 64'(xfer_cnt), 64'(xfer_before + 2));

    // Asynchronous reset in the middle of a set
    for (int i = 0; i < 5; i++) send_word(W'(8'h40 + i));
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_fill_cnt", 64'(fill_cnt), 64'(0));
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_word(W'(8'hA0 + i));
    in_valid = 1'b0;
    check("midrst_fresh_set", {a, b, c, d, e, f, g, h}, 64'hA0A1A2A3A4A5A6A7);
    idle(3);

    // Random gaps on in_valid
    xfer_before = xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send_word(8'h0F);
    end
    idle(3);
    check("gaps_one_set", 64'(xfer_cnt), 64'(xfer_before + 1));

`ifdef AND8_COLLECTOR_FLUSH_EN
    // Flush with fill_cnt==0 is ignored
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_empty_ignored", 64'(out_valid), 64'(0));
    // Partial set padded by flush
    out_ready = 1'b0;
    send_word(8'h3C);
    send_word(8'h5A);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'(1));
    check("flush_data", {a, b, c, d, e, f, g, h}, 64'h3C5AFFFFFFFFFFFF);
    check("flush_and", 64'(a & b & c & d & e & f & g & h), 64'h18);
    out_ready = 1'b1;
    idle(3);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
